// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory round-robin arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the port index of each outstanding transfer.
module fifo_v3
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = idx_width(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among several requesters,
// routing in-order responses back through an ID FIFO.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 3,
    parameter int unsigned ADDRESS_SIZE    = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NR_PORTS-1:0]                    req_port_req_i,
    input  logic [NR_PORTS-1:0][ADDRESS_SIZE-1:0]  req_port_address_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]    req_port_wdata_i,
    input  logic [NR_PORTS-1:0]                    req_port_we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]  req_port_be_i,
    output logic [NR_PORTS-1:0]                    req_port_gnt_o,
    output logic [NR_PORTS-1:0]                    req_port_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  req_port_rdata_o,
    output logic                                   mem_req_o,
    output logic [ADDRESS_SIZE-1:0]                mem_address_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

    localparam int unsigned IW = idx_width(NR_PORTS);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [IW-1:0]   r_last_grant;
    logic [IW-1:0]   r_lock_idx;
    logic [IW-1:0]   w_rr_idx;
    logic            w_rr_hit;
    logic [IW-1:0]   w_sel;
    logic            w_sel_req;
    logic            w_xfer;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [IW-1:0]   w_head;

    // Search for the first requester after the last granted one.
    always_comb begin
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        for (int i = 1; i <= int'(NR_PORTS); i++) begin
            int p;
            p = (int'(r_last_grant) + i) % int'(NR_PORTS);
            if (!w_rr_hit && req_port_req_i[IW'(p)]) begin
                w_rr_idx = IW'(p);
                w_rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel     = w_rr_idx;
        w_sel_req = w_rr_hit;
        if (r_state == LOCKED) begin
            w_sel     = r_lock_idx;
            w_sel_req = req_port_req_i[r_lock_idx];
        end
    end

    // Fullness uses the registered count only, so rvalid never feeds req.
    assign mem_req_o     = rst_ni & w_sel_req & ~w_full;
    assign w_xfer        = mem_req_o & mem_gnt_i;
    assign mem_address_o = req_port_address_i[w_sel];
    assign mem_wdata_o   = req_port_wdata_i[w_sel];
    assign mem_we_o      = req_port_we_i[w_sel];
    assign mem_be_o      = req_port_be_i[w_sel];

    always_comb begin
        req_port_gnt_o = '0;
        if (w_xfer) begin
            req_port_gnt_o[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB:     if (mem_req_o && !mem_gnt_i) w_state_nxt = LOCKED;
            LOCKED:  if (mem_gnt_i) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ARB;
            r_last_grant <= IW'(NR_PORTS - 1);
            r_lock_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && mem_req_o && !mem_gnt_i) begin
                r_lock_idx <= w_sel;
            end
            if (w_xfer) begin
                r_last_grant <= w_sel;
            end
        end
    end

    assign w_pop = rst_ni & mem_rvalid_i & ~w_empty;

    fifo_v3 #(
        .DEPTH      (MAX_OUTSTANDING),
        .DATA_WIDTH (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_xfer),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        req_port_rvalid_o = '0;
        if (w_pop) begin
            req_port_rvalid_o[w_head] = 1'b1;
        end
    end

    assign req_port_rdata_o = mem_rdata_i;

    // A response with nothing outstanding is dropped; flag it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_rvalid_i) begin
            assert (!w_empty)
            else $warning("mem_rr_arbiter: response dropped, no outstanding id");
        end
    end

endmodule
